// File: rtl/flash_sched_core.sv
// Scheduler endpoint of the FLASH req/grant interface: process table, priority scan,
// table-change handling and a free-running tick requester toward the bridge.
module flash_sched_core #(
    parameter int NUM_PROC    = 8,
    parameter int TICK_PERIOD = 1000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sched_req,
    output logic                      sched_grant,
    output logic [15:0]               next_process,
    input  logic                      change_req,
    input  logic [7:0]                change_type,
    input  logic [15:0]               change_pid,
    input  logic [7:0]                change_pri,
    input  logic [15:0]               change_state,
    output logic                      change_grant,
    output logic                      tick_req,
    input  logic                      tick_grant,
    output logic [$clog2(NUM_PROC):0] proc_count,
    output logic [2:0]                dbg_state_o,
    output logic [1:0]                dbg_tick_state_o
);
    localparam int IW   = $clog2(NUM_PROC);
    localparam int CNTW = IW + 1;
    localparam int CW   = $clog2(TICK_PERIOD);

    // Handshakes are four-phase: a grant rises only after its req is seen high,
    // stays high until the req is sampled low, then falls on the next edge.
    typedef enum logic [2:0] {IDLE, SCAN, SGRANT, CHG, CGRANT} state_e;
    typedef enum logic [1:0] {T_IDLE, T_REQ, T_REL} tstate_e;

    state_e            state_q;
    logic [IW:0]       idx_q;
    logic [15:0]       best_pid_q;
    logic [7:0]        best_pri_q;
    logic              best_vld_q;
    logic [15:0]       next_process_q;
    logic              sched_grant_q, change_grant_q;
    logic [7:0]        c_type_q, c_pri_q;
    logic [15:0]       c_pid_q, c_state_q;
    logic [NUM_PROC-1:0] valid_q;
    logic [15:0]       pid_q [NUM_PROC];
    logic [7:0]        pri_q [NUM_PROC];
    logic [15:0]       pst_q [NUM_PROC];
    logic [CNTW-1:0]   count_q;

    tstate_e           tstate_q;
    logic [CW-1:0]     tcnt_q;
    logic              tick_pend_q, tick_req_q;

    logic              hit_d, free_d, cand_d, wrap_d;
    logic [IW-1:0]     hit_idx_d, free_idx_d, scan_idx_d;

    // Lowest-index match and lowest-index free slot; descending loop lets the lowest win.
    always_comb begin
        hit_d      = 1'b0;
        hit_idx_d  = '0;
        free_d     = 1'b0;
        free_idx_d = '0;
        for (int i = NUM_PROC - 1; i >= 0; i--) begin
            if (valid_q[i] && pid_q[i] == c_pid_q) begin
                hit_d     = 1'b1;
                hit_idx_d = IW'(i);
            end
            if (!valid_q[i]) begin
                free_d     = 1'b1;
                free_idx_d = IW'(i);
            end
        end
    end

    always_comb begin
        scan_idx_d = idx_q[IW-1:0];
        cand_d     = valid_q[scan_idx_d] && (pst_q[scan_idx_d] == 16'h0000) &&
                     (!best_vld_q || pri_q[scan_idx_d] < best_pri_q);
        wrap_d     = (tcnt_q == CW'(TICK_PERIOD - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            best_pid_q     <= 16'hFFFF;
            best_pri_q     <= 8'hFF;
            best_vld_q     <= 1'b0;
            next_process_q <= 16'hFFFF;
            sched_grant_q  <= 1'b0;
            change_grant_q <= 1'b0;
            c_type_q       <= '0;
            c_pri_q        <= '0;
            c_pid_q        <= '0;
            c_state_q      <= '0;
            valid_q        <= '0;
            count_q        <= '0;
            for (int i = 0; i < NUM_PROC; i++) begin
                pid_q[i] <= '0;
                pri_q[i] <= '0;
                pst_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (change_req) begin
                        c_type_q  <= change_type;
                        c_pid_q   <= change_pid;
                        c_pri_q   <= change_pri;
                        c_state_q <= change_state;
                        state_q   <= CHG;
                    end else if (sched_req) begin
                        idx_q      <= '0;
                        best_vld_q <= 1'b0;
                        state_q    <= SCAN;
                    end
                end
                SCAN: begin
                    if (idx_q == CNTW'(NUM_PROC)) begin
                        next_process_q <= best_vld_q ? best_pid_q : 16'hFFFF;
                        sched_grant_q  <= 1'b1;
                        state_q        <= SGRANT;
                    end else begin
                        if (cand_d) begin
                            best_pid_q <= pid_q[scan_idx_d];
                            best_pri_q <= pri_q[scan_idx_d];
                            best_vld_q <= 1'b1;
                        end
                        idx_q <= idx_q + CNTW'(1);
                    end
                end
                SGRANT: begin
                    if (!sched_req) begin
                        sched_grant_q <= 1'b0;
                        state_q       <= IDLE;
                    end
                end
                CHG: begin
                    case (c_type_q)
                        8'h01: begin
                            if (hit_d) begin
                                pri_q[hit_idx_d] <= c_pri_q;
                                pst_q[hit_idx_d] <= c_state_q;
                            end else if (free_d) begin
                                valid_q[free_idx_d] <= 1'b1;
                                pid_q[free_idx_d]   <= c_pid_q;
                                pri_q[free_idx_d]   <= c_pri_q;
                                pst_q[free_idx_d]   <= c_state_q;
                                count_q             <= count_q + CNTW'(1);
                            end
                        end
                        8'h02: begin
                            if (hit_d) begin
                                valid_q[hit_idx_d] <= 1'b0;
                                count_q            <= count_q - CNTW'(1);
                            end
                        end
                        8'h03: begin
                            if (hit_d) begin
                                pri_q[hit_idx_d] <= c_pri_q;
                                pst_q[hit_idx_d] <= c_state_q;
                            end
                        end
                        default: ;
                    endcase
                    state_q <= CGRANT;
                end
                CGRANT: begin
                    if (!change_grant_q) begin
                        change_grant_q <= 1'b1;
                    end else if (!change_req) begin
                        change_grant_q <= 1'b0;
                        state_q        <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Wraps that land while a tick is outstanding collapse into a single pending tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tstate_q    <= T_IDLE;
            tcnt_q      <= '0;
            tick_pend_q <= 1'b0;
            tick_req_q  <= 1'b0;
        end else begin
            tcnt_q <= wrap_d ? '0 : tcnt_q + CW'(1);
            if (wrap_d) begin
                tick_pend_q <= 1'b1;
            end else if (tstate_q == T_IDLE && tick_pend_q) begin
                tick_pend_q <= 1'b0;
            end
            case (tstate_q)
                T_IDLE: begin
                    if (tick_pend_q) begin
                        tick_req_q <= 1'b1;
                        tstate_q   <= T_REQ;
                    end
                end
                T_REQ: begin
                    if (tick_grant) begin
                        tick_req_q <= 1'b0;
                        tstate_q   <= T_REL;
                    end
                end
                T_REL: begin
                    if (!tick_grant) tstate_q <= T_IDLE;
                end
                default: tstate_q <= T_IDLE;
            endcase
        end
    end

    assign sched_grant      = sched_grant_q;
    assign next_process     = next_process_q;
    assign change_grant     = change_grant_q;
    assign tick_req         = tick_req_q;
    assign proc_count       = count_q;
    assign dbg_state_o      = 3'(state_q);
    assign dbg_tick_state_o = 2'(tstate_q);
endmodule

// File: doc/flash_sched_core.md
# flash_sched_core

Scheduler-side endpoint of the FLASH request/grant interface. It sits below the HPS bridge and answers its schedule and change requests. It keeps a small process table, picks the next process to run, and initiates periodic tick requests toward the bridge. All three channels use four-phase req/grant handshakes. The bridge drops any request that arrives while a handshake is in progress, so this block must always complete every phase.

## Interface
- NUM_PROC, 8, number of process-table entries (power of two, 2..32)
- TICK_PERIOD, 1000, clock cycles between tick requests (≥ 4)
- clk  input  1  single clock; everything is on the rising edge
- rst  input  1  asynchronous, active-low reset
- sched_req  input  1  request for the next process
- sched_grant  output  1  next_process valid; held until sched_req falls
- next_process  output  16  selected pid; 16'hFFFF means none runnable
- change_req  input  1  table-change request
- change_type  input  8  8'h01 ADD, 8'h02 REMOVE, 8'h03 MODIFY; other codes are no-ops
- change_pid  input  16  target pid
- change_pri  input  8  priority; lower value is more urgent
- change_state  input  16  process state; 16'h0000 means runnable
- change_grant  output  1  change applied; held until change_req falls
- tick_req  output  1  periodic tick toward the bridge
- tick_grant  input  1  bridge acknowledges the tick
- proc_count  output  $clog2(NUM_PROC)+1  number of valid table entries

## Operation
- Table entry fields: valid, pid[15:0], pri[7:0], state[15:0].
- Main FSM states: IDLE, SCAN, SGRANT, CHG, CGRANT.
  - IDLE: change_req has precedence over sched_req when both are high.
  - IDLE with change_req=1: capture change_* into registers, then go to CHG.
  - IDLE with sched_req=1 and change_req=0: index←0, best←none, then go to SCAN.
- SCAN examines one entry per cycle, in index order 0..NUM_PROC-1.
  - An entry is a candidate if valid and state==0.
  - A candidate replaces best only if its pri is strictly less than best's pri, so ties keep the lowest index.
  - After the last index: next_process←best pid (16'hFFFF if none), then go to SGRANT.
- SGRANT: sched_grant=1. When sched_req is sampled 0, drop sched_grant and return to IDLE.
- CHG (exactly one cycle) matches the captured pid against all valid entries combinationally.
  - ADD, pid present: overwrite pri and state.
  - ADD, pid absent: write to the lowest-index invalid entry. If the table is full, make no change.
  - REMOVE: clear valid on the matching entry; absent pid is a no-op.
  - MODIFY: overwrite pri and state on the matching entry; absent pid is a no-op.
  - Unknown change_type: no change.
  - Then go to CGRANT in every case. Every request is granted, including failed ones.
- CGRANT: change_grant=1. When change_req is sampled 0, drop change_grant and return to IDLE.
- proc_count always equals the number of valid entries. It updates in the CHG cycle.
- Tick FSM runs independently of the main FSM. States: T_IDLE, T_REQ, T_REL.
  - Free-running counter wraps TICK_PERIOD-1 → 0. Each wrap sets tick_pend.
  - T_IDLE with tick_pend=1: tick_req=1, clear tick_pend, go to T_REQ.
  - T_REQ: when tick_grant=1, tick_req=0, go to T_REL.
  - T_REL: when tick_grant=0, go to T_IDLE.
  - A wrap during T_REQ or T_REL sets tick_pend; multiple wraps coalesce into one pending tick.
- Reset (asynchronous, any state, including mid-handshake):
  - sched_grant=0, change_grant=0, tick_req=0, next_process=16'hFFFF.
  - All valid bits cleared, proc_count=0, tick counter=0, tick_pend=0.
  - Main FSM→IDLE, tick FSM→T_IDLE.

## Timing
- All outputs are registered.
- sched_req sampled high in IDLE at edge k:
  - SCAN occupies edges k+1..k+NUM_PROC.
  - sched_grant and next_process are valid after edge k+NUM_PROC+1.
- change_req sampled high at edge k:
  - Table updated at edge k+1.
  - change_grant high after edge k+2.
- Grant release: grant falls one edge after the request is sampled low. The next request is accepted no earlier than the following edge.
- next_process holds its value until the next SCAN completes.
- tick_req rises one edge after the counter wrap when the tick FSM is in T_IDLE.
- tick_req falls one edge after tick_grant is sampled high.
- Changes are never interleaved with a SCAN. A change_req arriving during SCAN or SGRANT waits in IDLE.

## Test plan
- Reset release, NUM_PROC=4: sched_req=1 → sched_grant after 6 edges with next_process=16'hFFFF; all outputs match reset values before the request.
- ADD pid 5 pri 3, ADD pid 9 pri 1, ADD pid 7 pri 1, all state 0; then sched_req → next_process=9 (tie with pid 7 resolved to the lower index); proc_count=3.
- MODIFY pid 9 state=16'h0002, then sched_req → next_process=7. REMOVE pid 7, then sched_req → next_process=5.
- Fill all 4 entries, then ADD pid 42 → change_grant still asserts, proc_count stays 4, and a later scan never returns 42.
- TICK_PERIOD=8, tick_grant withheld for 20 cycles → exactly one tick_req pulse held during that time; after the grant handshake completes, exactly one further pending tick issues (coalesced).
- rst asserted while sched_grant=1 and tick_req=1 → both drop immediately (asynchronous), table empties; after release, sched_req → next_process=16'hFFFF.
